mem_sweep_master: RTL and testbench
===================================

Name: mem_sweep_master

Overview:
Bus initiator that drives the parallel read/write memory port used by the team's generate-replicated memory arrays (read, write, address, data_in out; data_out in). On a start request it writes a deterministic pattern to every word, then reads every word back and checks it. It reports an error count, the first failing address, and pass/done status. It replaces hand-written testbench stimulus and doubles as an on-chip memory BIST sequencer.

Parameters:
DATA_W, 32, width of data_in/data_out
ADDR_W, 4, width of address
DEPTH, 16, words swept, 1..2**ADDR_W
RD_LAT, 1, cycles after a read cycle at which data_out is sampled, 0..3 (0 = sampled at the edge ending the read cycle)

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level, sampled only in IDLE
seed  input  DATA_W  pattern base, captured when start is accepted
read  output  1  memory read strobe
write  output  1  memory write strobe
address  output  ADDR_W  memory word address
data_in  output  DATA_W  write data to memory
data_out  input  DATA_W  read data from memory
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at end of sweep
pass  output  1  result of last sweep, held until next accepted start
err_count  output  ADDR_W+1  mismatches in current/last sweep
first_err_addr  output  ADDR_W  address of first mismatch; 0 if none

Behaviour:
- Reset (async, immediate): state IDLE; read=write=busy=done=pass=0; address=0; data_in=0; err_count=0; first_err_addr=0; read-compare pipeline flushed. Memory contents are not touched.
- All outputs are registered.
- Pattern: expected(a) = seed + a, mod 2**DATA_W; wraps silently.
- States: IDLE -> WRITE -> GAP -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 at an edge captures seed, clears err_count/first_err_addr/pass, and enters WRITE. Numbering cycles from that edge:
  - Cycles 1..DEPTH (WRITE): write=1, read=0, address=0..DEPTH-1, data_in=expected(address).
  - Cycle DEPTH+1 (GAP): read=write=0, address=0, data_in=0.
  - Cycles DEPTH+2..2*DEPTH+1 (READ): read=1, address=0..DEPTH-1, data_in=0.
  - Next RD_LAT cycles (DRAIN): read=write=0.
  - Cycle 2*DEPTH+2+RD_LAT (DONE): done=1, pass=(err_count==0); then IDLE.
  - With the default parameters, done is high in cycle 35.
- Compare: each read cycle pushes {valid, address, expected} into an RD_LAT-deep pipeline. data_out is compared at the edge ending cycle (read cycle + RD_LAT).
- On mismatch: err_count increments (cannot overflow, max DEPTH). first_err_addr is loaded only on the first mismatch of the sweep.
- err_count and first_err_addr are final when done rises, and are held in IDLE.
- start while busy is ignored. In the DONE cycle start is not sampled. If start is still high in IDLE, a new sweep begins, with write first seen 2 cycles after done.
- Address counter returns to 0 after DEPTH-1 in each phase. With DEPTH < 2**ADDR_W, higher addresses are never driven.
- write and read are never high in the same cycle. There is always at least one idle cycle between the last write and the first read.
- Reset mid-sweep: outputs drop asynchronously before the next edge. There is no partial done/pass. After release, a sweep restarts from address 0 only on a new start.

Test Plan:
1. Default params, ideal memory model with RD_LAT=1, seed=0xDEADBEEF, start pulse -> writes 0xDEADBEEF..0xDEADBEFE to addr 0..15; reads at addr 0..15 in cycles 18..33; done in cycle 35; pass=1; err_count=0.
2. Model corrupts bit0 of addr 5 and returns 0 for addr 12 -> err_count=2, first_err_addr=5, pass=0 at done; values held in IDLE.
3. seed=0xFFFFFFF8 -> data_in at addr 7 = 0xFFFFFFFF, at addr 8 = 0x00000000; pass=1.
4. start held high for 40 cycles -> exactly one sweep per accept; start asserted in cycle 10 of a sweep has no effect; continuous start gives back-to-back sweeps with write 2 cycles after each done.
5. Assert reset asynchronously mid-cycle 20 (READ) -> read, busy, err_count go 0 before the next edge; no done pulse; after release plus a start pulse, a full sweep passes.
6. Rerun scenario 1 with RD_LAT=0 (combinational model) and RD_LAT=2 (2-stage model) -> pass=1, done in cycle 34 and cycle 36 respectively.

Source files
------------

// File: rtl/mem_sweep_master.sv
// Memory sweep initiator: writes seed+address to every word, reads each word back,
// and reports mismatch count, first failing address and pass/done status.
module mem_sweep_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ERR_MAX    = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]        DRAIN_LAST = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] seed_q, seed_n;
  logic [1:0]        drain_cnt, drain_n;
  logic [ADDR_W-1:0] addr_n, addr_inc, ferr_n;
  logic [DATA_W-1:0] din_n;
  logic              write_n, read_n, done_n, pass_n;
  logic [ADDR_W:0]   err_n;

  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;
  logic              mismatch;

  assign addr_inc = address + 1'b1;

  // Each read cycle's address and expected word travel RD_LAT stages so they
  // line up with the memory's returned data at the compare edge.
  generate
    if (RD_LAT == 0) begin : g_no_pipe
      assign cmp_valid = read;
      assign cmp_addr  = address;
      assign cmp_exp   = seed_q + DATA_W'(address);
    end else begin : g_pipe
      logic [RD_LAT-1:0]             pipe_v;
      logic [RD_LAT-1:0][ADDR_W-1:0] pipe_a;
      logic [RD_LAT-1:0][DATA_W-1:0] pipe_e;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_v <= '0;
          pipe_a <= '0;
          pipe_e <= '0;
        end else begin
          pipe_v[0] <= read;
          pipe_a[0] <= address;
          pipe_e[0] <= seed_q + DATA_W'(address);
          for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
            pipe_e[i] <= pipe_e[i-1];
          end
        end
      end

      assign cmp_valid = pipe_v[RD_LAT-1];
      assign cmp_addr  = pipe_a[RD_LAT-1];
      assign cmp_exp   = pipe_e[RD_LAT-1];
    end
  endgenerate

  assign mismatch = cmp_valid && (data_out != cmp_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = address;
    din_n   = '0;
    write_n = 1'b0;
    read_n  = 1'b0;
    done_n  = 1'b0;
    pass_n  = pass;
    seed_n  = seed_q;
    drain_n = drain_cnt;
    err_n   = err_count;
    ferr_n  = first_err_addr;

    if (mismatch && err_count != ERR_MAX) begin
      err_n = err_count + 1'b1;
      if (err_count == '0) begin
        ferr_n = cmp_addr;
      end
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WRITE;
          seed_n  = seed;
          addr_n  = '0;
          write_n = 1'b1;
          din_n   = seed;
          err_n   = '0;
          ferr_n  = '0;
          pass_n  = 1'b0;
        end
      end
      S_WRITE: begin
        if (address == LAST_ADDR) begin
          state_n = S_GAP;
          addr_n  = '0;
        end else begin
          write_n = 1'b1;
          addr_n  = addr_inc;
          din_n   = seed_q + DATA_W'(addr_inc);
        end
      end
      S_GAP: begin
        state_n = S_READ;
        read_n  = 1'b1;
        addr_n  = '0;
      end
      S_READ: begin
        if (address == LAST_ADDR) begin
          addr_n = '0;
          if (RD_LAT == 0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
          end else begin
            state_n = S_DRAIN;
            drain_n = '0;
          end
        end else begin
          read_n = 1'b1;
          addr_n = addr_inc;
        end
      end
      S_DRAIN: begin
        // Pass is taken from the count including the final compare landing now.
        if (drain_cnt == DRAIN_LAST) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          drain_n = drain_cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read           <= 1'b0;
      write          <= 1'b0;
      address        <= '0;
      data_in        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      seed_q         <= '0;
      drain_cnt      <= '0;
    end else begin
      read           <= read_n;
      write          <= write_n;
      address        <= addr_n;
      data_in        <= din_n;
      busy           <= (state_n != S_IDLE);
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      first_err_addr <= ferr_n;
      seed_q         <= seed_n;
      drain_cnt      <= drain_n;
    end
  end

endmodule

// File: tb/tb_mem_sweep_master.sv
// Scoreboard bench for mem_sweep_master: three instances (RD_LAT 0, 1, 2) share
// stimulus; each has its own memory model, predictor queue and monitor.
module tb_mem_sweep_master;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int N  = 3;

  typedef struct {
    int            per;
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          pass;
    logic [AW:0]   err;
    logic [AW-1:0] ferr;
  } ev_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed  = '0;

  logic [N-1:0]  rd_s, wr_s, busy_s, done_s, pass_s;
  logic [AW-1:0] addr_s [N];
  logic [DW-1:0] din_s  [N];
  logic [DW-1:0] dout_s [N];
  logic [AW:0]   err_s  [N];
  logic [AW-1:0] ferr_s [N];

  logic          fault_en  = 1'b0;
  logic [AW-1:0] flip_a    = '0;
  logic [AW-1:0] zero_a    = '0;
  logic [DW-1:0] flip_mask = 32'h1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Faulty memory read path; zero_a wins over flip_a when they coincide.
  function automatic logic [DW-1:0] faultRead(input logic [AW-1:0] a, input logic [DW-1:0] v);
    if (fault_en && a == zero_a) return '0;
    if (fault_en && a == flip_a) return v ^ flip_mask;
    return v;
  endfunction

  for (genvar g = 0; g < N; g++) begin : gen_dut
    logic [DW-1:0] mem [D];
    logic [DW-1:0] p1, p2;
    ev_t           exp_q [$];
    int            edge_cnt  = 0;
    int            next_ok   = 0;
    int            busy_lo   = 0;
    int            busy_hi   = -1;
    logic          held_pass = 1'b0;
    logic [AW:0]   held_err  = '0;
    logic [AW-1:0] held_ferr = '0;

    mem_sweep_master #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RD_LAT(g)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .seed           (seed),
      .read           (rd_s[g]),
      .write          (wr_s[g]),
      .address        (addr_s[g]),
      .data_in        (din_s[g]),
      .data_out       (dout_s[g]),
      .busy           (busy_s[g]),
      .done           (done_s[g]),
      .pass           (pass_s[g]),
      .err_count      (err_s[g]),
      .first_err_addr (ferr_s[g])
    );

    always @(posedge clk) if (wr_s[g]) mem[addr_s[g]] <= din_s[g];
    always @(posedge clk) begin
      p1 <= faultRead(addr_s[g], mem[addr_s[g]]);
      p2 <= p1;
    end

    if (g == 0) begin : g_lat0
      assign dout_s[g] = faultRead(addr_s[g], mem[addr_s[g]]);
    end else if (g == 1) begin : g_lat1
      assign dout_s[g] = p1;
    end else begin : g_lat2
      assign dout_s[g] = p2;
    end

    // Predictor: on an accepted start, queue every bus event of the sweep with its period.
    initial begin : predictor
      ev_t           e;
      int            a, nerr;
      logic [AW-1:0] ferr;
      logic [DW-1:0] s, ev;
      forever begin
        @(posedge clk);
        edge_cnt++;
        if (reset) begin
          exp_q.delete();
          next_ok = 0;
          busy_lo = 0;
          busy_hi = -1;
        end else if (start && edge_cnt >= next_ok) begin
          a = edge_cnt;
          s = seed;
          nerr = 0;
          ferr = '0;
          for (int i = 0; i < D; i++) begin
            e.per = a + i; e.kind = 0; e.addr = AW'(i); e.data = s + DW'(i);
            e.pass = 1'b0; e.err = '0; e.ferr = '0;
            exp_q.push_back(e);
          end
          for (int i = 0; i < D; i++) begin
            e.per = a + D + 1 + i; e.kind = 1; e.addr = AW'(i); e.data = '0;
            exp_q.push_back(e);
            ev = s + DW'(i);
            if (faultRead(AW'(i), ev) != ev) begin
              if (nerr == 0) ferr = AW'(i);
              nerr++;
            end
          end
          e.per = a + 2*D + 1 + g; e.kind = 2; e.addr = '0; e.data = '0;
          e.pass = (nerr == 0); e.err = (AW+1)'(nerr); e.ferr = ferr;
          exp_q.push_back(e);
          busy_lo = a;
          busy_hi = a + 2*D + 1 + g;
          next_ok = a + 2*D + 3 + g;
        end
      end
    end

    initial begin : monitor
      ev_t   e;
      int    kind;
      logic  exp_busy;
      string tag;
      tag = $sformatf("L%0d", g);
      forever begin
        @(negedge clk);
        if (reset) begin
          held_pass = 1'b0;
          held_err  = '0;
          held_ferr = '0;
        end else begin
          checkOutput({tag, " rd_wr_overlap"}, DW'(wr_s[g] & rd_s[g]), '0);
          if (done_s[g] || wr_s[g] || rd_s[g]) begin
            kind = done_s[g] ? 2 : (wr_s[g] ? 0 : 1);
            if (exp_q.size() == 0) begin
              checkOutput({tag, " unexpected_event_kind"}, DW'(kind + 1), '0);
            end else begin
              e = exp_q.pop_front();
              checkOutput({tag, " event_period"}, DW'(edge_cnt), DW'(e.per));
              checkOutput({tag, " event_kind"}, DW'(kind), DW'(e.kind));
              if (kind != 2) begin
                checkOutput({tag, " address"}, DW'(addr_s[g]), DW'(e.addr));
                checkOutput({tag, " data_in"}, din_s[g], e.data);
              end else begin
                checkOutput({tag, " done_pass"}, DW'(pass_s[g]), DW'(e.pass));
                checkOutput({tag, " done_err_count"}, DW'(err_s[g]), DW'(e.err));
                checkOutput({tag, " done_first_err"}, DW'(ferr_s[g]), DW'(e.ferr));
                held_pass = e.pass;
                held_err  = e.err;
                held_ferr = e.ferr;
              end
            end
          end else if (exp_q.size() > 0 && exp_q[0].per < edge_cnt) begin
            checkOutput({tag, " missed_event_period"}, DW'(edge_cnt), DW'(exp_q[0].per));
            void'(exp_q.pop_front());
          end
          exp_busy = (edge_cnt >= busy_lo) && (edge_cnt <= busy_hi);
          checkOutput({tag, " busy"}, DW'(busy_s[g]), DW'(exp_busy));
          if (!exp_busy) begin
            checkOutput({tag, " idle_pass"}, DW'(pass_s[g]), DW'(held_pass));
            checkOutput({tag, " idle_err_count"}, DW'(err_s[g]), DW'(held_err));
            checkOutput({tag, " idle_first_err"}, DW'(ferr_s[g]), DW'(held_ferr));
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] s, input int hold, input bit vary);
    seed  = s;
    start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (vary) seed = $urandom;
    end
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy_s != '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_s != '0) checkOutput("sweep_timeout busy", DW'(busy_s), '0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("L%0d reset read", g), DW'(rd_s[g]), '0);
      checkOutput($sformatf("L%0d reset write", g), DW'(wr_s[g]), '0);
      checkOutput($sformatf("L%0d reset busy", g), DW'(busy_s[g]), '0);
      checkOutput($sformatf("L%0d reset done", g), DW'(done_s[g]), '0);
      checkOutput($sformatf("L%0d reset pass", g), DW'(pass_s[g]), '0);
      checkOutput($sformatf("L%0d reset address", g), DW'(addr_s[g]), '0);
      checkOutput($sformatf("L%0d reset data_in", g), din_s[g], '0);
      checkOutput($sformatf("L%0d reset err_count", g), DW'(err_s[g]), '0);
      checkOutput($sformatf("L%0d reset first_err", g), DW'(ferr_s[g]), '0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Clean sweep with the reference seed.
    applyStimulus(32'hDEADBEEF, 1, 1'b0);
    waitIdle(200);
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("L%0d s1 pass", g), DW'(pass_s[g]), 32'h1);
      checkOutput($sformatf("L%0d s1 err_count", g), DW'(err_s[g]), '0);
    end

    // Bit-0 flip at 5 and stuck-zero at 12.
    fault_en = 1'b1; flip_a = 4'd5; flip_mask = 32'h1; zero_a = 4'd12;
    applyStimulus(32'h12345678, 1, 1'b0);
    waitIdle(200);
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("L%0d s2 err_count", g), DW'(err_s[g]), 32'd2);
      checkOutput($sformatf("L%0d s2 first_err", g), DW'(ferr_s[g]), 32'd5);
      checkOutput($sformatf("L%0d s2 pass", g), DW'(pass_s[g]), '0);
    end
    fault_en = 1'b0;

    // Pattern wraps past all-ones.
    applyStimulus(32'hFFFFFFF8, 1, 1'b0);
    waitIdle(200);

    // Start held: back-to-back sweeps, seed changing every cycle.
    applyStimulus($urandom, 80, 1'b1);
    waitIdle(200);

    // Start pulse in cycle 10 of a running sweep is ignored.
    applyStimulus($urandom, 1, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    seed  = $urandom;
    @(negedge clk);
    start = 1'b0;
    waitIdle(200);

    // Async reset mid-cycle 20 while reading, with a fault on address 0.
    fault_en = 1'b1; flip_a = 4'd0; flip_mask = 32'h80000000; zero_a = 4'd9;
    applyStimulus($urandom, 1, 1'b0);
    repeat (19) @(negedge clk);
    checkOutput("read high in cycle 20", DW'(rd_s), 32'h7);
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("L%0d err in cycle 20", g), DW'(err_s[g]), (g < 2) ? 32'd1 : 32'd0);
    end
    #1 reset = 1'b1;
    #1;
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("L%0d async read", g), DW'(rd_s[g]), '0);
      checkOutput($sformatf("L%0d async busy", g), DW'(busy_s[g]), '0);
      checkOutput($sformatf("L%0d async err_count", g), DW'(err_s[g]), '0);
      checkOutput($sformatf("L%0d async done", g), DW'(done_s[g]), '0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    fault_en = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus($urandom, 1, 1'b0);
    waitIdle(200);
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("L%0d after-reset pass", g), DW'(pass_s[g]), 32'h1);
    end

    // Random seeds and random fault placement.
    repeat (6) begin
      fault_en  = 1'($urandom_range(0, 1));
      flip_a    = AW'($urandom_range(0, D - 1));
      zero_a    = AW'($urandom_range(0, D - 1));
      flip_mask = $urandom;
      if (flip_mask == '0) flip_mask = 32'h1;
      applyStimulus($urandom, 1, 1'b0);
      waitIdle(200);
    end

    repeat (3) @(negedge clk);
    checkOutput("L0 queue drained", DW'(gen_dut[0].exp_q.size()), '0);
    checkOutput("L1 queue drained", DW'(gen_dut[1].exp_q.size()), '0);
    checkOutput("L2 queue drained", DW'(gen_dut[2].exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
